blocklist_ctrl: RTL and testbench

BLOCKLIST_CTRL -- requirements
Module: blocklist_ctrl

---
 rtl/blocklist_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_blocklist_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blocklist_ctrl.sv
// Blocklist lookup/config controller: linear scan of a 256x32 single-port BRAM
// with host append/clear, round-robin arbitration between lookup and config.
module blocklist_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lookup_req,
  input  logic [31:0] lookup_ip,
  output logic        lookup_done,
  output logic        lookup_hit,
  output logic [7:0]  lookup_index,
  input  logic        cfg_wr_req,
  input  logic        cfg_clr_req,
  input  logic [31:0] cfg_ip,
  output logic        cfg_ack,
  output logic        cfg_err,
  output logic [8:0]  entry_count,
  output logic        busy,
  output logic [7:0]  bram_addr,
  output logic        bram_we,
  output logic [31:0] bram_wdata,
  input  logic [31:0] bram_rdata,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic GRANT_LK  = 1'b0;
  localparam logic GRANT_CFG = 1'b1;

  logic [1:0]  state_q, state_d;
  logic [31:0] ip_q, ip_d;
  logic [8:0]  count_q, count_d;
  logic        last_grant_q, last_grant_d;
  logic        dead_q, dead_d;
  logic [7:0]  addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic        issue_q, issue_d;
  logic        cmp_v_q, cmp_v_d;
  logic [7:0]  cmp_idx_q, cmp_idx_d;
  logic        done_q, done_d;
  logic        hit_q, hit_d;
  logic [7:0]  index_q, index_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;

  logic cfg_pend;
  logic grant_lk;
  logic grant_cfg;

  // On contention the class not granted last wins; after reset the bit holds
  // "lookup", so the first contended cycle goes to config.
  assign cfg_pend  = cfg_wr_req | cfg_clr_req;
  assign grant_lk  = lookup_req & (~cfg_pend | (last_grant_q == GRANT_CFG));
  assign grant_cfg = cfg_pend & ~grant_lk;

  always_comb begin
    state_d      = state_q;
    ip_d         = ip_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    dead_d       = dead_q;
    addr_d       = addr_q;
    we_d         = 1'b0;
    wdata_d      = wdata_q;
    issue_d      = issue_q;
    cmp_v_d      = cmp_v_q;
    cmp_idx_d    = cmp_idx_q;
    done_d       = 1'b0;
    hit_d        = 1'b0;
    index_d      = 8'd0;
    ack_d        = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (dead_q) begin
          // requests still high right after a pulse belong to the finished op
          dead_d = 1'b0;
        end else if (grant_lk) begin
          ip_d         = lookup_ip;
          last_grant_d = GRANT_LK;
          addr_d       = 8'd0;
          cmp_v_d      = 1'b0;
          if (count_q == 9'd0) begin
            state_d = RESP;
            done_d  = 1'b1;
            issue_d = 1'b0;
          end else begin
            state_d = SCAN;
            issue_d = 1'b1;
          end
        end else if (grant_cfg) begin
          last_grant_d = GRANT_CFG;
          if (cfg_clr_req) begin
            count_d = 9'd0;
            state_d = RESP;
            ack_d   = 1'b1;
          end else if (count_q[8]) begin
            state_d = RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = WRITE;
            we_d    = 1'b1;
            addr_d  = count_q[7:0];
            wdata_d = cfg_ip;
          end
        end
      end

      SCAN: begin
        // bram_rdata this cycle belongs to the address issued last cycle
        cmp_v_d   = issue_q;
        cmp_idx_d = addr_q;
        if (issue_q) begin
          if (({1'b0, addr_q} + 9'd1) < count_q) begin
            addr_d = addr_q + 8'd1;
          end else begin
            issue_d = 1'b0;
          end
        end
        if (cmp_v_q && (bram_rdata == ip_q)) begin
          state_d = RESP;
          done_d  = 1'b1;
          hit_d   = 1'b1;
          index_d = cmp_idx_q;
          issue_d = 1'b0;
        end else if (cmp_v_q && ({1'b0, cmp_idx_q} == (count_q - 9'd1))) begin
          state_d = RESP;
          done_d  = 1'b1;
          issue_d = 1'b0;
        end
      end

      WRITE: begin
        state_d = RESP;
        ack_d   = 1'b1;
        count_d = count_q + 9'd1;
      end

      RESP: begin
        state_d = IDLE;
        dead_d  = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ip_q         <= 32'd0;
      count_q      <= 9'd0;
      last_grant_q <= GRANT_LK;
      dead_q       <= 1'b0;
      addr_q       <= 8'd0;
      we_q         <= 1'b0;
      wdata_q      <= 32'd0;
      issue_q      <= 1'b0;
      cmp_v_q      <= 1'b0;
      cmp_idx_q    <= 8'd0;
      done_q       <= 1'b0;
      hit_q        <= 1'b0;
      index_q      <= 8'd0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ip_q         <= ip_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      dead_q       <= dead_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      issue_q      <= issue_d;
      cmp_v_q      <= cmp_v_d;
      cmp_idx_q    <= cmp_idx_d;
      done_q       <= done_d;
      hit_q        <= hit_d;
      index_q      <= index_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  assign lookup_done  = done_q;
  assign lookup_hit   = hit_q;
  assign lookup_index = index_q;
  assign cfg_ack      = ack_q;
  assign cfg_err      = err_q;
  assign entry_count  = count_q;
  assign busy         = (state_q != IDLE);
  assign bram_addr    = addr_q;
  assign bram_we      = we_q;
  assign bram_wdata   = wdata_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_blocklist_ctrl.sv
// Bench for blocklist_ctrl: table of single operations, then fill/full, contention
// and reset-during-scan sequences; results go through an expected-result queue.
module tb_blocklist_ctrl;

  localparam int OP_LK  = 0;
  localparam int OP_WR  = 1;
  localparam int OP_CLR = 2;

  logic        clk;
  logic        rst_n;
  logic        lookup_req;
  logic [31:0] lookup_ip;
  logic        lookup_done;
  logic        lookup_hit;
  logic [7:0]  lookup_index;
  logic        cfg_wr_req;
  logic        cfg_clr_req;
  logic [31:0] cfg_ip;
  logic        cfg_ack;
  logic        cfg_err;
  logic [8:0]  entry_count;
  logic        busy;
  logic [7:0]  bram_addr;
  logic        bram_we;
  logic [31:0] bram_wdata;
  logic [31:0] bram_rdata;
  logic [1:0]  state_dbg;

  blocklist_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_req   (lookup_req),
    .lookup_ip    (lookup_ip),
    .lookup_done  (lookup_done),
    .lookup_hit   (lookup_hit),
    .lookup_index (lookup_index),
    .cfg_wr_req   (cfg_wr_req),
    .cfg_clr_req  (cfg_clr_req),
    .cfg_ip       (cfg_ip),
    .cfg_ack      (cfg_ack),
    .cfg_err      (cfg_err),
    .entry_count  (entry_count),
    .busy         (busy),
    .bram_addr    (bram_addr),
    .bram_we      (bram_we),
    .bram_wdata   (bram_wdata),
    .bram_rdata   (bram_rdata),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // BRAM model: registered read, one cycle latency
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_wdata;
    bram_rdata <= mem[bram_addr];
  end

  // scoreboard: {is_cfg, hit_or_err, index}
  logic [9:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int pushed_cnt = 0;
  int overlap_cnt = 0;
  int we_cnt = 0;
  logic [7:0]  last_wa = 8'd0;
  logic [31:0] last_wd = 32'd0;
  logic [7:0]  scan_max = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [9:0] act;
    logic [9:0] exp;
    if (rst_n) begin
      if (bram_we) begin
        we_cnt++;
        last_wa = bram_addr;
        last_wd = bram_wdata;
      end
      if (busy && !bram_we && (bram_addr > scan_max)) scan_max = bram_addr;
      if (lookup_done && cfg_ack) overlap_cnt++;
      if (lookup_done || cfg_ack) begin
        pulse_cnt++;
        act = lookup_done ? {1'b0, lookup_hit, lookup_index} : {1'b1, cfg_err, 8'h00};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %0h with nothing expected (cycle %0d)", act, cyc);
        end else begin
          exp = exp_q.pop_front();
          check("scoreboard", {22'd0, act}, {22'd0, exp});
        end
      end
    end
  end

  // driver: one operation, waits for its pulse, holds the request one extra cycle
  task automatic run_op(input int op, input logic [31:0] ip, input logic flag,
                        input logic [7:0] idx, input int lat, input logic [8:0] cnt);
    int n0;
    int we0;
    bit seen;
    exp_q.push_back({(op != OP_LK), flag, (op == OP_LK) ? idx : 8'h00});
    pushed_cnt++;
    we0 = we_cnt;
    scan_max = 8'd0;
    @(posedge clk); #1;
    case (op)
      OP_LK:   begin lookup_ip = ip; lookup_req = 1'b1; end
      OP_WR:   begin cfg_ip = ip; cfg_wr_req = 1'b1; end
      default: cfg_clr_req = 1'b1;
    endcase
    seen = 0;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      if (busy) begin seen = 1; break; end
    end
    check("accept", {31'd0, seen}, 32'd1);
    n0 = cyc;
    seen = 0;
    for (int t = 0; t < 600; t++) begin
      if (lookup_done || cfg_ack) begin seen = 1; break; end
      @(negedge clk);
    end
    check("pulse_seen", {31'd0, seen}, 32'd1);
    check("latency", cyc - n0 + 1, lat);
    check("entry_count", {23'd0, entry_count}, {23'd0, cnt});
    if (op == OP_LK && !flag)
      check("scan_last_addr", {24'd0, scan_max}, (cnt == 9'd0) ? 32'd0 : {23'd0, cnt - 9'd1});
    if (op == OP_WR) begin
      check("we_pulses", we_cnt - we0, flag ? 32'd0 : 32'd1);
      if (!flag) begin
        check("we_addr", {24'd0, last_wa}, {23'd0, cnt - 9'd1});
        check("we_data", last_wd, ip);
      end
    end
    @(posedge clk);
    @(posedge clk); #1;
    lookup_req = 1'b0;
    cfg_wr_req = 1'b0;
    cfg_clr_req = 1'b0;
  endtask

  // lookup and append raised together; each side drops one cycle after its pulse
  task automatic contend(input logic [31:0] lip, input logic [31:0] cip,
                         input logic [9:0] first, input logic [9:0] second);
    int lk_cd;
    int cf_cd;
    int seen;
    exp_q.push_back(first);
    exp_q.push_back(second);
    pushed_cnt += 2;
    lk_cd = 0;
    cf_cd = 0;
    seen = 0;
    @(posedge clk); #1;
    lookup_ip = lip; cfg_ip = cip;
    lookup_req = 1'b1; cfg_wr_req = 1'b1;
    for (int t = 0; t < 800; t++) begin
      @(negedge clk);
      if (lookup_done) begin lk_cd = 2; seen++; end
      if (cfg_ack) begin cf_cd = 2; seen++; end
      @(posedge clk); #1;
      if (lk_cd > 0) begin lk_cd--; if (lk_cd == 0) lookup_req = 1'b0; end
      if (cf_cd > 0) begin cf_cd--; if (cf_cd == 0) cfg_wr_req = 1'b0; end
      if (seen >= 2 && !lookup_req && !cfg_wr_req) break;
    end
    check("contend_pulses", seen, 2);
    lookup_req = 1'b0;
    cfg_wr_req = 1'b0;
  endtask

  typedef struct {
    int          op;
    logic [31:0] ip;
    logic        flag;
    logic [7:0]  idx;
    int          lat;
    logic [8:0]  cnt;
  } vec_t;

  vec_t tbl[12];
  logic [31:0] fill_ip[256];

  initial begin
    int k;
    int p0;
    tbl[0]  = '{OP_LK,  32'h0A000001, 1'b0, 8'd0, 1, 9'd0};
    tbl[1]  = '{OP_WR,  32'h0A000001, 1'b0, 8'd0, 2, 9'd1};
    tbl[2]  = '{OP_WR,  32'h0A000002, 1'b0, 8'd0, 2, 9'd2};
    tbl[3]  = '{OP_WR,  32'h0A000003, 1'b0, 8'd0, 2, 9'd3};
    tbl[4]  = '{OP_LK,  32'h0A000003, 1'b1, 8'd2, 5, 9'd3};
    tbl[5]  = '{OP_LK,  32'h0A000001, 1'b1, 8'd0, 3, 9'd3};
    tbl[6]  = '{OP_LK,  32'h0A000009, 1'b0, 8'd0, 5, 9'd3};
    tbl[7]  = '{OP_WR,  32'h0A000001, 1'b0, 8'd0, 2, 9'd4};
    tbl[8]  = '{OP_WR,  32'h0A000005, 1'b0, 8'd0, 2, 9'd5};
    tbl[9]  = '{OP_LK,  32'h0A000001, 1'b1, 8'd0, 3, 9'd5};
    tbl[10] = '{OP_CLR, 32'h00000000, 1'b0, 8'd0, 1, 9'd0};
    tbl[11] = '{OP_LK,  32'h0A000002, 1'b0, 8'd0, 1, 9'd0};

    rst_n = 1'b0;
    lookup_req = 1'b0; lookup_ip = 32'd0;
    cfg_wr_req = 1'b0; cfg_clr_req = 1'b0; cfg_ip = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {lookup_done, lookup_hit, lookup_index, cfg_ack, cfg_err, busy, bram_we, bram_addr},
          32'd0);
    check("reset_count", {23'd0, entry_count}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op(tbl[i].op, tbl[i].ip, tbl[i].flag, tbl[i].idx, tbl[i].lat, tbl[i].cnt);

    // fill to capacity, then overflow append and worst-case scans
    for (int i = 0; i < 256; i++) begin
      fill_ip[i] = {8'hAC, 8'($urandom_range(0, 255)), 16'(i)};
      run_op(OP_WR, fill_ip[i], 1'b0, 8'd0, 2, 9'(i + 1));
    end
    run_op(OP_WR, 32'h0B0B0B0B, 1'b1, 8'd0, 1, 9'd256);
    run_op(OP_LK, 32'h08080808, 1'b0, 8'd0, 258, 9'd256);
    run_op(OP_LK, fill_ip[255], 1'b1, 8'd255, 258, 9'd256);
    k = $urandom_range(0, 254);
    run_op(OP_LK, fill_ip[k], 1'b1, 8'(k), 3 + k, 9'd256);

    // contention: after a config grant lookup wins, after a lookup grant config wins
    run_op(OP_CLR, 32'd0, 1'b0, 8'd0, 1, 9'd0);
    run_op(OP_WR, 32'h0A000007, 1'b0, 8'd0, 2, 9'd1);
    contend(32'h0A000007, 32'h0A000008, {1'b0, 1'b1, 8'd0}, {1'b1, 1'b0, 8'd0});
    run_op(OP_LK, 32'h0A000008, 1'b1, 8'd1, 4, 9'd2);
    contend(32'h0A000009, 32'h0A000009, {1'b1, 1'b0, 8'd0}, {1'b0, 1'b1, 8'd2});
    check("contend_count", {23'd0, entry_count}, 32'd3);

    // reset in the middle of a 100-entry scan
    run_op(OP_CLR, 32'd0, 1'b0, 8'd0, 1, 9'd0);
    for (int i = 0; i < 100; i++)
      run_op(OP_WR, {16'hC0A8, 16'(i)}, 1'b0, 8'd0, 2, 9'(i + 1));
    p0 = pulse_cnt;
    @(posedge clk); #1;
    lookup_ip = 32'h08080808;
    lookup_req = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    check("busy_mid_scan", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs",
          {lookup_done, lookup_hit, lookup_index, cfg_ack, cfg_err, busy, bram_we, bram_addr},
          32'd0);
    check("rst_async_count", {23'd0, entry_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    lookup_req = 1'b0;
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    check("no_pulse_after_rst", pulse_cnt - p0, 32'd0);
    check("count_after_rst", {23'd0, entry_count}, 32'd0);
    run_op(OP_LK, 32'hC0A80005, 1'b0, 8'd0, 1, 9'd0);

    repeat (5) @(negedge clk);
    check("no_overlap", overlap_cnt, 32'd0);
    check("pulse_total", pulse_cnt, pushed_cnt);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
